// File: rtl/fmap_pkg.sv
// Shared constants and types for the ping/pong feature-map store.
// FMAP_OUT_REG_EN adds an output register stage, making the read latency 2 cycles.
package fmap_pkg;

    localparam int N_BANK_DEF = 8;
    localparam int DW_DEF     = 16;
    localparam int AW_DEF     = 10;

    typedef logic [1:0] tiles_t;

`ifdef FMAP_OUT_REG_EN
    localparam int READ_LAT = 2;
`else
    localparam int READ_LAT = 1;
`endif

endpackage

// File: rtl/fmap_bank_dp.sv
// One DW x (2*DEPTH) bank split into two halves. Address bit [AW] selects the half.
// Port A writes the write half, port 1 reads the other half, and port B serves read port 2.
module fmap_bank_dp #(
    parameter int DW    = 16,
    parameter int AW    = 10,
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW:0]   waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW:0]   raddr1_i,
    input  logic [AW:0]   raddr2_i,
    output logic [DW-1:0] rdata1_o,
    output logic [DW-1:0] rdata2_o
);

    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] rdata1_q, rdata2_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            if (waddr_i[AW]) mem1[waddr_i[AW-1:0]] <= wdata_i;
            else             mem0[waddr_i[AW-1:0]] <= wdata_i;
        end
    end

    // The output registers are resettable and hold their value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else if (re_i) begin
            rdata1_q <= raddr1_i[AW] ? mem1[raddr1_i[AW-1:0]] : mem0[raddr1_i[AW-1:0]];
            rdata2_q <= raddr2_i[AW] ? mem1[raddr2_i[AW-1:0]] : mem0[raddr2_i[AW-1:0]];
        end
    end

    assign rdata1_o = rdata1_q;
    assign rdata2_o = rdata2_q;

endmodule

// File: rtl/fmap_pingpong_bram.sv
// Double-buffered feature-map store. The producer fills one half while the consumer reads the other.
// Defining FMAP_OUT_REG_EN adds an output register stage, giving a read latency of 2.
module fmap_pingpong_bram
    import fmap_pkg::*;
#(
    parameter int N_BANK = N_BANK_DEF,
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int DEPTH  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [N_BANK*DW-1:0] wr_data,
    input  logic [N_BANK-1:0]    wr_mask,
    input  logic                 wr_done,
    output logic                 wr_ready,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr1,
    input  logic [AW-1:0]        rd_addr2,
    output logic [N_BANK*DW-1:0] rd_data1,
    output logic [N_BANK*DW-1:0] rd_data2,
    output logic                 rd_valid,
    input  logic                 rd_done,
    output logic                 rd_ready,
    output tiles_t               tiles
);

    logic [1:0]          full_q, full_d;
    logic                wsel_q, wsel_d, rsel_q, rsel_d;
    logic [READ_LAT-1:0] vld_q;
    logic                wr_go, rd_go, wdone_go, rdone_go;
    logic [N_BANK*DW-1:0] bank_rd1, bank_rd2;

    assign wr_ready = !full_q[wsel_q];
    assign rd_ready = full_q[rsel_q];
    assign tiles    = tiles_t'({1'b0, full_q[0]} + {1'b0, full_q[1]});

    assign wr_go    = wr_en   && wr_ready;
    assign rd_go    = rd_en   && rd_ready;
    assign wdone_go = wr_done && wr_ready;
    assign rdone_go = rd_done && rd_ready;

    // A simultaneous write-done and read-done always hit different halves.
    always_comb begin
        full_d = full_q;
        wsel_d = wsel_q;
        rsel_d = rsel_q;
        if (wdone_go) begin
            full_d[wsel_q] = 1'b1;
            wsel_d         = !wsel_q;
        end
        if (rdone_go) begin
            full_d[rsel_q] = 1'b0;
            rsel_d         = !rsel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= '0;
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
            vld_q  <= '0;
        end else begin
            full_q <= full_d;
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
            vld_q  <= READ_LAT'({vld_q, rd_go});
        end
    end

    assign rd_valid = vld_q[READ_LAT-1];

    for (genvar k = 0; k < N_BANK; k++) begin : g_bank
        fmap_bank_dp #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_bank (
            .clk      (clk),
            .rst      (rst),
            .we_i     (wr_go && wr_mask[k]),
            .waddr_i  ({wsel_q, wr_addr}),
            .wdata_i  (wr_data[DW*k +: DW]),
            .re_i     (rd_go),
            .raddr1_i ({rsel_q, rd_addr1}),
            .raddr2_i ({rsel_q, rd_addr2}),
            .rdata1_o (bank_rd1[DW*k +: DW]),
            .rdata2_o (bank_rd2[DW*k +: DW])
        );
    end

`ifdef FMAP_OUT_REG_EN
    logic [N_BANK*DW-1:0] rd_data1_q, rd_data2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data1_q <= '0;
            rd_data2_q <= '0;
        end else begin
            rd_data1_q <= bank_rd1;
            rd_data2_q <= bank_rd2;
        end
    end

    assign rd_data1 = rd_data1_q;
    assign rd_data2 = rd_data2_q;
`else
    assign rd_data1 = bank_rd1;
    assign rd_data2 = bank_rd2;
`endif

endmodule

// File: tb/tb_fmap_pingpong_bram.sv
// Directed self-checking bench for fmap_pingpong_bram; it follows READ_LAT, so it runs with or without FMAP_OUT_REG_EN.
module tb_fmap_pingpong_bram;
    import fmap_pkg::*;

    localparam int NB = 8;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int W  = NB * DW;

    typedef logic [W-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0, wr_done = 1'b0, rd_en = 1'b0, rd_done = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
    vec_t          wr_data = '0;
    logic [NB-1:0] wr_mask = '0;
    vec_t          rd_data1, rd_data2;
    logic          wr_ready, rd_ready, rd_valid;
    tiles_t        tiles;

    int checks = 0;
    int passes = 0;

    fmap_pingpong_bram #(.N_BANK(NB), .DW(DW), .AW(AW), .DEPTH(1024)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_done(wr_done), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_valid(rd_valid),
        .rd_done(rd_done), .rd_ready(rd_ready), .tiles(tiles)
    );

    always #5 clk = ~clk;

    // Lane k = base + 0x100*k + addr.
    function automatic vec_t pat(input logic [15:0] base, input int a);
        vec_t v;
        for (int k = 0; k < NB; k++) v[DW*k +: DW] = base + 16'(k * 256) + 16'(a);
        return v;
    endfunction

    function automatic vec_t fill(input logic [15:0] w);
        vec_t v;
        for (int k = 0; k < NB; k++) v[DW*k +: DW] = w;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input vec_t d, input logic [NB-1:0] m);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
        tick;
        wr_en = 1'b0;
    endtask

    task automatic wdone;
        wr_done = 1'b1;
        tick;
        wr_done = 1'b0;
    endtask

    task automatic rdone;
        rd_done = 1'b1;
        tick;
        rd_done = 1'b0;
    endtask

    task automatic rd_issue(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        rd_en = 1'b1; rd_addr1 = a1; rd_addr2 = a2;
        tick;
        rd_en = 1'b0;
        repeat (READ_LAT - 1) tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick;
        rst = 1'b0;
        checks++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %b want 1", wr_ready); else passes++;
        checks++; if (rd_ready !== 1'b0) $display("FAIL reset_rd_ready: got %b want 0", rd_ready); else passes++;
        checks++; if (tiles !== 2'd0) $display("FAIL reset_tiles: got %0d want 0", tiles); else passes++;
        checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else passes++;
        checks++; if (rd_data1 !== '0) $display("FAIL reset_rd_data1: got %h want 0", rd_data1); else passes++;
    endtask

    task automatic test_basic;
        int lat;
        for (int a = 0; a < 4; a++) wr(AW'(a), pat(16'h0000, a), '1);
        wdone;
        checks++; if (tiles !== 2'd1) $display("FAIL basic_tiles: got %0d want 1", tiles); else passes++;
        checks++; if (rd_ready !== 1'b1) $display("FAIL basic_rd_ready: got %b want 1", rd_ready); else passes++;
        checks++; if (wr_ready !== 1'b1) $display("FAIL basic_wr_ready: got %b want 1", wr_ready); else passes++;
        rd_en = 1'b1; rd_addr1 = 10'd2; rd_addr2 = 10'd3;
        tick;
        rd_en = 1'b0;
        lat = 1;
        while (!rd_valid && lat < 6) begin
            tick;
            lat++;
        end
        checks++; if (lat !== READ_LAT) $display("FAIL basic_latency: got %0d want %0d", lat, READ_LAT); else passes++;
        checks++; if (rd_valid !== 1'b1) $display("FAIL basic_rd_valid: got %b want 1", rd_valid); else passes++;
        checks++; if (rd_data1[DW*5 +: DW] !== 16'h0502) $display("FAIL basic_lane5_p1: got %h want 0502", rd_data1[DW*5 +: DW]); else passes++;
        checks++; if (rd_data2[DW*5 +: DW] !== 16'h0503) $display("FAIL basic_lane5_p2: got %h want 0503", rd_data2[DW*5 +: DW]); else passes++;
        checks++; if (rd_data1 !== pat(16'h0000, 2)) $display("FAIL basic_rd_data1: got %h want %h", rd_data1, pat(16'h0000, 2)); else passes++;
        checks++; if (rd_data2 !== pat(16'h0000, 3)) $display("FAIL basic_rd_data2: got %h want %h", rd_data2, pat(16'h0000, 3)); else passes++;
        tick;
        checks++; if (rd_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", rd_valid); else passes++;
        checks++; if (rd_data1 !== pat(16'h0000, 2)) $display("FAIL basic_hold: got %h want %h", rd_data1, pat(16'h0000, 2)); else passes++;
    endtask

    task automatic test_full;
        for (int a = 0; a < 4; a++) wr(AW'(a), pat(16'h2000, a), '1);
        wdone;
        checks++; if (tiles !== 2'd2) $display("FAIL full_tiles: got %0d want 2", tiles); else passes++;
        checks++; if (wr_ready !== 1'b0) $display("FAIL full_wr_ready: got %b want 0", wr_ready); else passes++;
        wr(10'd0, fill(16'hFFFF), '1);
        wdone;
        checks++; if (tiles !== 2'd2) $display("FAIL full_wdone_ignored: got %0d want 2", tiles); else passes++;
        rd_issue(10'd0, 10'd1);
        checks++; if (rd_data1 !== pat(16'h0000, 0)) $display("FAIL full_write_dropped: got %h want %h", rd_data1, pat(16'h0000, 0)); else passes++;
        checks++; if (rd_data2 !== pat(16'h0000, 1)) $display("FAIL full_half0_p2: got %h want %h", rd_data2, pat(16'h0000, 1)); else passes++;
        rdone;
        checks++; if (tiles !== 2'd1) $display("FAIL full_after_rdone: got %0d want 1", tiles); else passes++;
        checks++; if (wr_ready !== 1'b1) $display("FAIL full_wr_ready_back: got %b want 1", wr_ready); else passes++;
        // Read issued in the same cycle as rd_done must still return.
        rd_en = 1'b1; rd_done = 1'b1; rd_addr1 = 10'd3; rd_addr2 = 10'd2;
        tick;
        rd_en = 1'b0; rd_done = 1'b0;
        repeat (READ_LAT - 1) tick;
        checks++; if (rd_valid !== 1'b1) $display("FAIL full_done_read_valid: got %b want 1", rd_valid); else passes++;
        checks++; if (rd_data1 !== pat(16'h2000, 3)) $display("FAIL full_half1_p1: got %h want %h", rd_data1, pat(16'h2000, 3)); else passes++;
        checks++; if (rd_data2 !== pat(16'h2000, 2)) $display("FAIL full_half1_p2: got %h want %h", rd_data2, pat(16'h2000, 2)); else passes++;
        checks++; if (tiles !== 2'd0) $display("FAIL full_empty: got %0d want 0", tiles); else passes++;
    endtask

    task automatic test_mask;
        vec_t exp;
        wr(10'd5, fill(16'hAAAA), '1);
        wr(10'd5, fill(16'h1234), 8'b0000_0001);
        wdone;
        rd_issue(10'd5, 10'd5);
        exp = fill(16'hAAAA);
        exp[DW-1:0] = 16'h1234;
        checks++; if (rd_data1 !== exp) $display("FAIL mask_p1: got %h want %h", rd_data1, exp); else passes++;
        checks++; if (rd_data2 !== exp) $display("FAIL mask_p2: got %h want %h", rd_data2, exp); else passes++;
    endtask

    task automatic test_simultaneous;
        wr(10'd7, pat(16'h3000, 7), '1);
        wr_done = 1'b1; rd_done = 1'b1;
        tick;
        wr_done = 1'b0; rd_done = 1'b0;
        checks++; if (tiles !== 2'd1) $display("FAIL simul_tiles: got %0d want 1", tiles); else passes++;
        checks++; if (wr_ready !== 1'b1) $display("FAIL simul_wr_ready: got %b want 1", wr_ready); else passes++;
        rd_issue(10'd7, 10'd7);
        checks++; if (rd_data1 !== pat(16'h3000, 7)) $display("FAIL simul_rsel: got %h want %h", rd_data1, pat(16'h3000, 7)); else passes++;
        wr(10'd7, pat(16'h4000, 7), '1);
        wdone;
        checks++; if (tiles !== 2'd2) $display("FAIL simul_wsel_tiles: got %0d want 2", tiles); else passes++;
        rdone;
        rd_issue(10'd7, 10'd0);
        checks++; if (rd_data1 !== pat(16'h4000, 7)) $display("FAIL simul_wsel_data: got %h want %h", rd_data1, pat(16'h4000, 7)); else passes++;
        checks++; if (rd_data2 !== pat(16'h0000, 0)) $display("FAIL simul_half0_orig: got %h want %h", rd_data2, pat(16'h0000, 0)); else passes++;
        rdone;
    endtask

    task automatic test_idle;
        rd_issue(10'd1, 10'd1);
        checks++; if (rd_valid !== 1'b0) $display("FAIL idle_rd_valid: got %b want 0", rd_valid); else passes++;
        checks++; if (rd_data1 !== pat(16'h4000, 7)) $display("FAIL idle_hold: got %h want %h", rd_data1, pat(16'h4000, 7)); else passes++;
        rdone;
        checks++; if (tiles !== 2'd0) $display("FAIL idle_rdone_tiles: got %0d want 0", tiles); else passes++;
        checks++; if (rd_ready !== 1'b0) $display("FAIL idle_rd_ready: got %b want 0", rd_ready); else passes++;
    endtask

    task automatic test_rst_mid;
        wr(10'd0, fill(16'h5555), '1);
        wdone;
        checks++; if (tiles !== 2'd1) $display("FAIL rstmid_pre_tiles: got %0d want 1", tiles); else passes++;
        rd_issue(10'd0, 10'd0);
        checks++; if (rd_data1 !== fill(16'h5555)) $display("FAIL rstmid_pre_data: got %h want %h", rd_data1, fill(16'h5555)); else passes++;
        wr_en = 1'b1; wr_addr = 10'd1; wr_data = fill(16'h6666); wr_mask = '1;
        rst = 1'b1;
        tick;
        rst = 1'b0; wr_en = 1'b0;
        checks++; if (tiles !== 2'd0) $display("FAIL rstmid_tiles: got %0d want 0", tiles); else passes++;
        checks++; if (rd_valid !== 1'b0) $display("FAIL rstmid_rd_valid: got %b want 0", rd_valid); else passes++;
        checks++; if (rd_data1 !== '0) $display("FAIL rstmid_rd_data1: got %h want 0", rd_data1); else passes++;
        checks++; if (rd_data2 !== '0) $display("FAIL rstmid_rd_data2: got %h want 0", rd_data2); else passes++;
        checks++; if (wr_ready !== 1'b1) $display("FAIL rstmid_wr_ready: got %b want 1", wr_ready); else passes++;
        checks++; if (rd_ready !== 1'b0) $display("FAIL rstmid_rd_ready: got %b want 0", rd_ready); else passes++;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_full;
        test_mask;
        test_simultaneous;
        test_idle;
        test_rst_mid;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fmap_pingpong_bram.md
Name: fmap_pingpong_bram

Overview:
- Parametrised, double-buffered feature-map store between consecutive conv layers.
- N_BANK parallel DW-bit banks, so one address serves one word per channel lane.
- Two tile halves (ping/pong):
  - The producer layer writes one half while the consumer layer reads the other through two independent read ports.
  - Hand-over uses done/ready handshakes and replaces the fixed, unmanaged per-layer bank wrappers.

Parameters:
- N_BANK, 8, number of parallel banks (channel lanes).
- DW, 16, data width per bank.
- AW, 10, address width per half.
- DEPTH, 1024, words per bank per half (must be ≤ 2**AW).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address in the current write half
- wr_data  in  N_BANK*DW  write data; bank k uses bits [DW*(k+1)-1:DW*k]
- wr_mask  in  N_BANK  per-bank write enable
- wr_done  in  1  pulse: producer has finished the tile in the write half
- wr_ready  out  1  write half is free
- rd_en  in  1  read strobe (both ports)
- rd_addr1  in  AW  read port 1 address
- rd_addr2  in  AW  read port 2 address
- rd_data1  out  N_BANK*DW  read port 1 data
- rd_data2  out  N_BANK*DW  read port 2 data
- rd_valid  out  1  rd_data1/rd_data2 hold valid data
- rd_done  in  1  pulse: consumer has finished the read half
- rd_ready  out  1  read half holds a complete tile
- tiles  out  2  number of full halves (0..2)

Behaviour:
Clocking and reset
- All state changes on posedge clk.
- rst clears full[1:0], wsel, rsel, rd_valid, rd_data1, rd_data2 and the pipeline to 0.
- Memory contents are not reset.
- rst mid-tile discards both tiles. The first cycle after rst has wr_ready=1, rd_ready=0, tiles=0.

Status outputs
- wr_ready = !full[wsel].
- rd_ready = full[rsel].
- tiles = full[0]+full[1].

Write path
- When wr_en && wr_ready, bank k writes wr_data lane k at {wsel, wr_addr} if wr_mask[k].
- wr_en while !wr_ready is dropped with no side effects.

Write hand-over
- When wr_done && wr_ready: full[wsel] <= 1 and wsel toggles.
- wr_done while !wr_ready is ignored.

Read path
- When rd_en && rd_ready, both ports read at {rsel, rd_addr1} / {rsel, rd_addr2}.
- Data and rd_valid appear 1 cycle later.
- If !(rd_en && rd_ready): rd_valid=0 next cycle and rd_data holds its previous value.

Read hand-over
- When rd_done && rd_ready: full[rsel] <= 0 and rsel toggles.
- rd_done while !rd_ready is ignored.
- Reads already issued in the rd_done cycle still return data and rd_valid=1 on the next cycle.

Simultaneous events
- wr_done and rd_done in the same cycle act on different halves and are both applied.
- tiles is unchanged in that case.

Address sharing and collisions
- wsel==rsel occurs only when both halves are empty or both are full, so reads and writes never both act on the same half.
- Port A of each half serves writes when the half is the write half, and read port 1 otherwise. Port B always serves read port 2.
- Addresses ≥ DEPTH give undefined data. Nothing wraps.

Optional Feature:
- Macro: FMAP_OUT_REG_EN.
- Defined:
  - An extra output register stage on rd_data1, rd_data2 and rd_valid.
  - Read latency becomes 2 cycles.
  - The extra stage is also cleared by rst.
- Undefined: read latency is 1 cycle, as above.

Decomposition:
- Package fmap_pkg:
  - Default constants N_BANK_DEF=8, DW_DEF=16, AW_DEF=10.
  - Typedef for the 2-bit tile count.
  - Localparam READ_LAT, equal to 1, or 2 under FMAP_OUT_REG_EN.
- Sub-module fmap_bank_dp:
  - One DW×(2*DEPTH) true dual-port bank.
  - 1-cycle synchronous read; read-during-write on the same port returns old data.
  - Instantiated N_BANK times with a generate loop. The top holds only the selectors, full flags, handshake logic and muxing.

Test Plan:
- Reset, then write addr 0..3 with lane k = 16'h0100*k+addr, mask all ones; pulse wr_done → tiles=1, rd_ready=1, wr_ready=1. Read addr1=2, addr2=3 → next cycle rd_valid=1, lane5 = 16'h0502 / 16'h0503.
- Fill both halves without rd_done → tiles=2, wr_ready=0. A further write of 16'hFFFF to addr 0 is dropped; after rd_done, half 0 reads back its original data once refilled.
- wr_mask=8'b0000_0001 over prior data 16'hAAAA → only lane0 changes; lanes 1..7 still read 16'hAAAA.
- tiles=1 with wr_done and rd_done in the same cycle → tiles stays 1, wsel and rsel both toggle.
- rd_en while rd_ready=0 → rd_valid=0. rd_done at tiles=0 → ignored, tiles stays 0.
- Assert rst mid-write with tiles=1 → next cycle tiles=0, rd_valid=0, rd_data=0. Under FMAP_OUT_REG_EN, the first read returns data with rd_valid high exactly 2 cycles after rd_en.
